clap_detector: RTL and testbench
================================

CLAP_DETECTOR -- requirements
Module: clap_detector

Interface
REQ-001 SHALL have parameter THRESHOLD, default 12'd512, minimum magnitude counted as loud.
REQ-002 SHALL have parameter MIN_PEAK, default 4, minimum consecutive loud samples for a clap.
REQ-003 SHALL have parameter MAX_PEAK, default 64, loud-run length above which the event is noise, not a clap.
REQ-004 SHALL have parameter HOLDOFF, default 100, refractory length in samples.
REQ-005 SHALL have parameter WINDOW, default 2000, double-clap window in samples; used only under CLAP_DOUBLE_EN.
REQ-006 SHALL have port clk, input, 1 bit, sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port sample_valid, input, 1 bit, one-cycle strobe marking a new mic_in sample.
REQ-009 SHALL have port mic_in, input, 12 bits, unsigned microphone sample with midscale 2048.
REQ-010 SHALL have port clap_pulse, output, 1 bit, one-cycle pulse per accepted clap; this is the welcome-screen trigger source.
REQ-011 SHALL have port menu_en, output, 1 bit, menu enable level that toggles on each clap_pulse.
REQ-012 SHALL have port clap_count, output, 4 bits, accepted claps, saturating at 15.

Function
REQ-013 SHALL compute mag = |mic_in - 2048| as a 12-bit unsigned value; mic_in=0 gives 2048, mic_in=4095 gives 2047.
REQ-014 SHALL treat a sample as loud when mag >= THRESHOLD.
REQ-015 SHALL advance the FSM and its counters only on cycles with sample_valid=1; with sample_valid=0, all state holds.
REQ-016 FSM states: IDLE, ABOVE, HOLDOFF, and WAIT2 (WAIT2 only under the macro).
REQ-017 IDLE: a loud sample SHALL go to ABOVE with run=1.
REQ-018 ABOVE, loud sample: run SHALL increment, saturating at MAX_PEAK+1; reaching MAX_PEAK+1 SHALL go to HOLDOFF with no clap.
REQ-019 ABOVE, quiet sample with run >= MIN_PEAK: the clap is qualified; SHALL go to HOLDOFF with hold=0.
REQ-020 ABOVE, quiet sample with run < MIN_PEAK: SHALL return to IDLE as a glitch, with no clap.
REQ-021 HOLDOFF: SHALL count valid samples and leave after HOLDOFF of them; loud samples are ignored throughout.
REQ-022 A qualified clap SHALL assert clap_pulse for exactly one cycle, the cycle after the qualifying sample edge.
REQ-023 menu_en and clap_count SHALL update on that same edge.
REQ-024 clap_count SHALL stay at 15 on further claps.

Reset
REQ-025 reset=1 SHALL force, on the next edge: state=IDLE, all counters 0, clap_pulse=0, menu_en=0, clap_count=0.
REQ-026 Reset SHALL take priority over a simultaneous sample_valid or clap qualification; a clap in progress is discarded.

Configuration
REQ-027 With macro CLAP_DOUBLE_EN defined: a first qualified clap SHALL go HOLDOFF -> WAIT2 with no pulse.
REQ-028 With CLAP_DOUBLE_EN, WAIT2 behaves as IDLE for detection; a second qualified clap SHALL assert clap_pulse.
REQ-029 With CLAP_DOUBLE_EN, the second clap SHALL be accepted only if it starts within WINDOW valid samples of WAIT2 entry.
REQ-030 With CLAP_DOUBLE_EN, window expiry SHALL return to IDLE with no pulse.
REQ-031 Without CLAP_DOUBLE_EN, every qualified clap SHALL pulse, and HOLDOFF SHALL exit to IDLE.

Structure
REQ-032 Package clap_pkg SHALL hold the FSM state encoding, the MIDSCALE=2048 constant, and the counter width constants.
REQ-033 A sub-module mic_magnitude SHALL compute the combinational mag value.
REQ-034 The FSM, counters and outputs SHALL live in clap_detector.

Verification (defaults)
REQ-035 A 6-sample burst of mic_in=3000 then quiet -> one clap_pulse, menu_en 0->1, clap_count=1.
REQ-036 A 3-sample burst of mic_in=2800 -> no pulse; state returns to IDLE.
REQ-037 A 70-sample loud run -> no pulse; HOLDOFF is entered.
REQ-038 A second burst 50 samples after a clap -> ignored; the same burst at 150 samples -> second pulse, menu_en back to 0.
REQ-039 reset asserted during ABOVE -> all outputs 0 next cycle; no pulse follows.
REQ-040 Under CLAP_DOUBLE_EN: two claps 500 samples apart -> one pulse; two claps 2200 samples apart -> no pulse.

Source files
------------

// File: rtl/clap_pkg.sv
// Shared definitions for the clap detector: FSM encoding, midscale and counter widths.
package clap_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ABOVE   = 2'd1,
      S_HOLDOFF = 2'd2,
      S_WAIT2   = 2'd3
   } state_t;

   localparam int SAMPLE_W = 12;
   localparam int RUN_W    = 8;
   localparam int TIMER_W  = 16;
   localparam int COUNT_W  = 4;

   localparam logic [SAMPLE_W-1:0] MIDSCALE  = 12'd2048;
   localparam logic [COUNT_W-1:0]  COUNT_MAX = 4'd15;

endpackage

// File: rtl/mic_magnitude.sv
// Distance of an unsigned microphone sample from midscale (|mic_in - 2048|).
module mic_magnitude
   import clap_pkg::*;
(
   input  logic [SAMPLE_W-1:0] mic_in,
   output logic [SAMPLE_W-1:0] mag
);

   // Subtract in whichever direction keeps the result non-negative.
   always_comb begin
      if (mic_in >= MIDSCALE) begin
         mag = mic_in - MIDSCALE;
      end else begin
         mag = MIDSCALE - mic_in;
      end
   end

endmodule

// File: rtl/clap_detector.sv
// Clap detector: qualifies loud runs of MIN_PEAK..MAX_PEAK samples as claps,
// applies a refractory holdoff, and drives the clap pulse, menu toggle and count.
// Optional macro CLAP_DOUBLE_EN: only the second of two claps within WINDOW
// samples produces a pulse.
module clap_detector
   import clap_pkg::*;
#(
   parameter logic [SAMPLE_W-1:0] THRESHOLD = 12'd512,
   parameter int                  MIN_PEAK  = 4,
   parameter int                  MAX_PEAK  = 64,
   parameter int                  HOLDOFF   = 100,
   parameter int                  WINDOW    = 2000
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] mic_in,
   output logic                clap_pulse,
   output logic                menu_en,
   output logic [COUNT_W-1:0]  clap_count
);

   state_t               state_q, state_d;
   logic [RUN_W-1:0]     run_q, run_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [TIMER_W-1:0]   timer_limit;
   logic [SAMPLE_W-1:0]  mag;
   logic                 loud;
   logic                 fire;
`ifdef CLAP_DOUBLE_EN
   logic                 armed_q, armed_d;
`endif

   mic_magnitude u_mag (
      .mic_in (mic_in),
      .mag    (mag)
   );

   assign loud = (mag >= THRESHOLD);

   // One timer serves both the holdoff and the double-clap window, since the
   // two states are never active together.
   assign timer_limit = (state_q == S_WAIT2) ? TIMER_W'(WINDOW) : TIMER_W'(HOLDOFF);

   // Next-state and counter logic; nothing moves unless a new sample arrives.
   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      timer_d = timer_q;
      fire    = 1'b0;
`ifdef CLAP_DOUBLE_EN
      armed_d = armed_q;
`endif
      if (sample_valid) begin
         case (state_q)
            S_IDLE: begin
               if (loud) begin
                  state_d = S_ABOVE;
                  run_d   = RUN_W'(1);
               end
            end
            S_ABOVE: begin
               if (loud) begin
                  if (run_q + RUN_W'(1) >= RUN_W'(MAX_PEAK + 1)) begin
                     state_d = S_HOLDOFF;
                     run_d   = '0;
                     timer_d = '0;
`ifdef CLAP_DOUBLE_EN
                     armed_d = 1'b0;
`endif
                  end else begin
                     run_d = run_q + RUN_W'(1);
                  end
               end else if (run_q >= RUN_W'(MIN_PEAK)) begin
                  state_d = S_HOLDOFF;
                  run_d   = '0;
                  timer_d = '0;
`ifdef CLAP_DOUBLE_EN
                  if (armed_q) begin
                     fire    = 1'b1;
                     armed_d = 1'b0;
                  end else begin
                     armed_d = 1'b1;
                  end
`else
                  fire = 1'b1;
`endif
               end else begin
                  state_d = S_IDLE;
                  run_d   = '0;
`ifdef CLAP_DOUBLE_EN
                  armed_d = 1'b0;
`endif
               end
            end
            S_HOLDOFF: begin
               if (timer_q + TIMER_W'(1) >= timer_limit) begin
                  timer_d = '0;
`ifdef CLAP_DOUBLE_EN
                  state_d = armed_q ? S_WAIT2 : S_IDLE;
`else
                  state_d = S_IDLE;
`endif
               end else begin
                  timer_d = timer_q + TIMER_W'(1);
               end
            end
`ifdef CLAP_DOUBLE_EN
            S_WAIT2: begin
               if (loud) begin
                  state_d = S_ABOVE;
                  run_d   = RUN_W'(1);
                  timer_d = '0;
               end else if (timer_q + TIMER_W'(1) >= timer_limit) begin
                  state_d = S_IDLE;
                  timer_d = '0;
                  armed_d = 1'b0;
               end else begin
                  timer_d = timer_q + TIMER_W'(1);
               end
            end
`endif
            default: begin
               state_d = S_IDLE;
               run_d   = '0;
               timer_d = '0;
            end
         endcase
      end
   end

   // State, counters and outputs; reset wins over any sample or clap on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         run_q      <= '0;
         timer_q    <= '0;
         clap_pulse <= 1'b0;
         menu_en    <= 1'b0;
         clap_count <= '0;
`ifdef CLAP_DOUBLE_EN
         armed_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         run_q      <= run_d;
         timer_q    <= timer_d;
         clap_pulse <= fire;
`ifdef CLAP_DOUBLE_EN
         armed_q    <= armed_d;
`endif
         if (fire) begin
            menu_en <= ~menu_en;
            if (clap_count != COUNT_MAX) begin
               clap_count <= clap_count + COUNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_clap_detector.sv
// Scoreboard bench for clap_detector: stimulus pushes expected pulses, a
// monitor pops and compares them whenever clap_pulse is seen.
module tb_clap_detector;

   typedef struct {
      logic       menu;
      logic [3:0] count;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sample_valid = 1'b0;
   logic [11:0] mic_in = 12'd2048;
   logic        clap_pulse;
   logic        menu_en;
   logic [3:0]  clap_count;

   int          check_cnt = 0;
   int          pass_cnt  = 0;
   exp_t        exp_q[$];
   logic        exp_menu  = 1'b0;
   logic [3:0]  exp_count = 4'd0;
   logic        prev_pulse = 1'b0;

   clap_detector dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .mic_in       (mic_in),
      .clap_pulse   (clap_pulse),
      .menu_en      (menu_en),
      .clap_count   (clap_count)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      check_cnt++;
      if (actual == expected) begin
         pass_cnt++;
      end else begin
         $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   // Drives n valid samples of val, each followed by gap idle cycles carrying loud junk.
   task automatic applyStimulus(input logic [11:0] val, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         sample_valid = 1'b1;
         mic_in       = val;
         @(negedge clk);
         sample_valid = 1'b0;
         mic_in       = 12'd4095;
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
         end
      end
   endtask

   task automatic doClap(input logic [11:0] val, input int run);
      applyStimulus(val, run, 0);
      applyStimulus(12'd2048, 1, 0);
   endtask

   task automatic expectClap();
      exp_t e;
      exp_menu = ~exp_menu;
      if (exp_count != 4'd15) exp_count = exp_count + 4'd1;
      e.menu  = exp_menu;
      e.count = exp_count;
      exp_q.push_back(e);
   endtask

   task automatic cooldown();
      applyStimulus(12'd2048, 100, 1);
   endtask

   task automatic checkpoint(input string name);
      checkOutput(name, exp_q.size(), 0);
   endtask

   // Monitor: every observed pulse must be single-cycle and match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (clap_pulse === 1'b1) begin
         checkOutput("pulse_width", int'(prev_pulse), 0);
         checkOutput("pulse_expected", int'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("menu_en", int'(menu_en), int'(e.menu));
            checkOutput("clap_count", int'(clap_count), int'(e.count));
         end
      end
      prev_pulse = (clap_pulse === 1'b1);
   end

   // Watchdog so a stuck run still terminates.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main directed sequence.
   initial begin
      @(negedge clk);
      reset        = 1'b1;
      sample_valid = 1'b1;
      mic_in       = 12'd3000;
      repeat (3) @(negedge clk);
      reset        = 1'b0;
      sample_valid = 1'b0;
      checkOutput("reset_pulse", int'(clap_pulse), 0);
      checkOutput("reset_menu", int'(menu_en), 0);
      checkOutput("reset_count", int'(clap_count), 0);

`ifdef CLAP_DOUBLE_EN
      doClap(12'd3000, 6);
      applyStimulus(12'd2048, 493, 0);
      expectClap();
      doClap(12'd3000, 6);
      cooldown();
      checkpoint("double_within_window");
      doClap(12'd3000, 6);
      applyStimulus(12'd2048, 2200, 0);
      doClap(12'd3000, 6);
      applyStimulus(12'd2048, 2200, 0);
      checkpoint("double_outside_window");
      checkOutput("double_count", int'(clap_count), int'(exp_count));
      checkOutput("double_menu", int'(menu_en), int'(exp_menu));
`else
      expectClap();
      doClap(12'd3000, 6);
      checkOutput("first_menu", int'(menu_en), 1);
      checkOutput("first_count", int'(clap_count), 1);
      cooldown();
      checkpoint("first_clap");

      applyStimulus(12'd2800, 3, 0);
      applyStimulus(12'd2048, 1, 0);
      expectClap();
      doClap(12'd0, 6);
      cooldown();
      checkpoint("glitch_then_clap");

      expectClap();
      doClap(12'd2560, 4);
      cooldown();
      applyStimulus(12'd2559, 10, 0);
      applyStimulus(12'd1537, 10, 0);
      applyStimulus(12'd2048, 1, 0);
      checkpoint("threshold_edges");

      expectClap();
      doClap(12'd4095, 64);
      cooldown();
      checkpoint("max_peak_clap");

      applyStimulus(12'd3000, 70, 0);
      doClap(12'd3000, 6);
      cooldown();
      checkpoint("noise_run");
      checkOutput("count_after_noise", int'(clap_count), int'(exp_count));

      expectClap();
      doClap(12'd3000, 6);
      applyStimulus(12'd2048, 50, 0);
      doClap(12'd3000, 6);
      applyStimulus(12'd2048, 93, 0);
      expectClap();
      doClap(12'd3000, 6);
      checkOutput("menu_back", int'(menu_en), int'(exp_menu));

      applyStimulus(12'd2048, 99, 0);
      doClap(12'd3000, 4);
      expectClap();
      doClap(12'd3000, 4);
      cooldown();
      checkpoint("holdoff_edge");

      for (int k = 0; k < 9; k++) begin
         expectClap();
         doClap(12'd3000, 5);
         applyStimulus(12'd2048, 100, 0);
      end
      checkpoint("saturation_claps");
      checkOutput("count_saturated", int'(clap_count), 15);

      applyStimulus(12'd3000, 5, 0);
      reset        = 1'b1;
      sample_valid = 1'b1;
      mic_in       = 12'd2048;
      @(negedge clk);
      reset        = 1'b0;
      sample_valid = 1'b0;
      exp_menu     = 1'b0;
      exp_count    = 4'd0;
      checkOutput("rst_above_pulse", int'(clap_pulse), 0);
      checkOutput("rst_above_menu", int'(menu_en), 0);
      checkOutput("rst_above_count", int'(clap_count), 0);
      applyStimulus(12'd2048, 1, 0);
      applyStimulus(12'd3000, 3, 0);
      applyStimulus(12'd2048, 1, 0);
      expectClap();
      doClap(12'd3000, 6);
      cooldown();
      checkpoint("after_reset_clap");
`endif

      repeat (5) @(negedge clk);
      checkpoint("final_queue");
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
